// File: rtl/rx_acq_ctrl_if.sv
// Bundles every non-clock/reset signal of rx_acq_ctrl.
//   master modport: the controlling side (software config and datapath pulses in,
//                   applied config and status back)
//   slave modport : rx_acq_ctrl itself
// Config inputs : en, manual, m_man, bw_man, ss_man, thr_sel, thr_man, thr_auto
// Pulse inputs  : corr_dtct, crc_ok, crc_err (one cycle each)
// Outputs       : m_out, bw_out, ss_out, thr_out, frsync_ctrl, dp_rst, locked,
//                 state_o, n_relock (all registered in the controller)
interface rx_acq_ctrl_if;
    logic        en;
    logic        manual;
    logic [2:0]  m_man;
    logic [2:0]  bw_man;
    logic [3:0]  ss_man;
    logic        thr_sel;
    logic [23:0] thr_man;
    logic [23:0] thr_auto;
    logic        corr_dtct;
    logic        crc_ok;
    logic        crc_err;

    logic [2:0]  m_out;
    logic [2:0]  bw_out;
    logic [3:0]  ss_out;
    logic [23:0] thr_out;
    logic [1:0]  frsync_ctrl;
    logic        dp_rst;
    logic        locked;
    logic [2:0]  state_o;
    logic [15:0] n_relock;

    modport master (
        output en, manual, m_man, bw_man, ss_man, thr_sel, thr_man, thr_auto,
        output corr_dtct, crc_ok, crc_err,
        input  m_out, bw_out, ss_out, thr_out, frsync_ctrl, dp_rst, locked,
        input  state_o, n_relock
    );

    modport slave (
        input  en, manual, m_man, bw_man, ss_man, thr_sel, thr_man, thr_auto,
        input  corr_dtct, crc_ok, crc_err,
        output m_out, bw_out, ss_out, thr_out, frsync_ctrl, dp_rst, locked,
        output state_o, n_relock
    );
endinterface

// File: rtl/rx_acq_ctrl.sv
// Receive-chain acquisition/lock supervisor.
// Sequences the (m, bw) configuration applied to the datapath, holds the datapath
// in reset for RST_CYC cycles after every reconfiguration, declares lock after
// LOCK_N consecutive CRC passes and drops it after LOSS_N consecutive CRC fails or
// a silent frame watchdog. Auto mode scans the (m, bw) table, manual mode holds the
// software-supplied codes.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - rx_acq_ctrl_if.slave: config/pulse inputs, registered config/status outputs
module rx_acq_ctrl #(
    parameter int unsigned M_MAX     = 4,
    parameter int unsigned BW_MAX    = 5,
    parameter int unsigned RST_CYC   = 16,
    parameter int unsigned DWELL_CYC = 2000000,
    parameter int unsigned FRAME_TO  = 500000,
    parameter int unsigned LOCK_N    = 3,
    parameter int unsigned LOSS_N    = 4,
    parameter int unsigned CNT_W     = 24
) (
    input logic          clk,
    input logic          rst,
    rx_acq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StSettle    = 3'd1,
        StSearch    = 3'd2,
        StWaitFrame = 3'd3,
        StLocked    = 3'd4,
        StLost      = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] RstLast   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] FrameLast = CNT_W'(FRAME_TO - 1);
    localparam logic [7:0]       LockN     = 8'(LOCK_N);
    localparam logic [7:0]       LossN     = 8'(LOSS_N);
    localparam logic [2:0]       MMax      = 3'(M_MAX);
    localparam logic [2:0]       BwMax     = 3'(BW_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;    // dwell / frame watchdog
    logic [7:0]       vcnt_q, vcnt_d;  // consecutive ok (WAIT_FRAME) or err (LOCKED)
    logic [2:0]       m_idx_q, bw_idx_q;
    logic [2:0]       m_nxt, bw_nxt;
    logic [2:0]       m_cfg, bw_cfg;
    logic             adv;
    logic             chg;
    logic             ok_v, err_v;

    logic             manual_q;
    logic [2:0]       m_man_q, bw_man_q;
    logic [2:0]       m_out_q, bw_out_q;
    logic [3:0]       ss_out_q;
    logic [23:0]      thr_out_q;
    logic [1:0]       frsync_q;
    logic             dp_rst_q, locked_q;
    logic [15:0]      n_relock_q;

    // Simultaneous verdicts count as a failure only.
    assign err_v = bus.crc_err;
    assign ok_v  = bus.crc_ok & ~bus.crc_err;

    // Software reconfiguration seen against last cycle's inputs; ss_out_q holds
    // last cycle's ss_man.
    assign chg = (bus.manual != manual_q) |
                 (bus.manual & ((bus.m_man != m_man_q) | (bus.bw_man != bw_man_q) |
                                (bus.ss_man != ss_out_q)));

    // Next scan index: bw inner loop, m outer, wrapping to (0,0).
    always_comb begin
        m_nxt  = m_idx_q;
        bw_nxt = bw_idx_q + 3'd1;
        if (bw_idx_q == BwMax) begin
            bw_nxt = 3'd0;
            m_nxt  = (m_idx_q == MMax) ? 3'd0 : m_idx_q + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        vcnt_d  = vcnt_q;
        adv     = 1'b0;
        if (!bus.en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: state_d = StSettle;
                StSettle: begin
                    if (cnt_q == RstLast) state_d = StSearch;
                end
                StSearch: begin
                    if (chg) begin
                        state_d = StSettle;
                    end else if (bus.corr_dtct) begin
                        state_d = StWaitFrame;
                    end else if (cnt_q == DwellLast) begin
                        state_d = StSettle;
                        adv     = ~bus.manual;
                    end
                end
                StWaitFrame: begin
                    if (chg) begin
                        state_d = StSettle;
                    end else if (err_v) begin
                        cnt_d  = '0;
                        vcnt_d = '0;
                    end else if (ok_v) begin
                        cnt_d = '0;
                        if (vcnt_q + 8'd1 == LockN) state_d = StLocked;
                        else                        vcnt_d  = vcnt_q + 8'd1;
                    end else if (cnt_q == FrameLast) begin
                        state_d = StSettle;
                        adv     = ~bus.manual;
                    end
                end
                StLocked: begin
                    if (chg) begin
                        state_d = StSettle;
                    end else if (err_v) begin
                        cnt_d = '0;
                        if (vcnt_q + 8'd1 == LossN) state_d = StLost;
                        else                        vcnt_d  = vcnt_q + 8'd1;
                    end else if (ok_v) begin
                        cnt_d  = '0;
                        vcnt_d = '0;
                    end else if (cnt_q == FrameLast) begin
                        state_d = StLost;
                    end
                end
                StLost:  state_d = StSettle;
                default: state_d = StIdle;
            endcase
        end
        // Every state change restarts both counters.
        if (state_d != state_q) begin
            cnt_d  = '0;
            vcnt_d = '0;
        end
    end

    // Config applied when (re)entering SETTLE.
    always_comb begin
        if (bus.manual) begin
            m_cfg  = bus.m_man;
            bw_cfg = bus.bw_man;
        end else if (adv) begin
            m_cfg  = m_nxt;
            bw_cfg = bw_nxt;
        end else begin
            m_cfg  = m_idx_q;
            bw_cfg = bw_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            vcnt_q     <= '0;
            m_idx_q    <= '0;
            bw_idx_q   <= '0;
            manual_q   <= 1'b0;
            m_man_q    <= '0;
            bw_man_q   <= '0;
            m_out_q    <= '0;
            bw_out_q   <= '0;
            ss_out_q   <= '0;
            thr_out_q  <= '0;
            frsync_q   <= 2'b00;
            dp_rst_q   <= 1'b1;
            locked_q   <= 1'b0;
            n_relock_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vcnt_q    <= vcnt_d;
            manual_q  <= bus.manual;
            m_man_q   <= bus.m_man;
            bw_man_q  <= bus.bw_man;
            ss_out_q  <= bus.ss_man;
            thr_out_q <= bus.thr_sel ? bus.thr_auto : bus.thr_man;

            dp_rst_q <= (state_d == StIdle) || (state_d == StSettle);
            locked_q <= (state_d == StLocked);
            case (state_d)
                StWaitFrame: frsync_q <= 2'b01;
                StLocked:    frsync_q <= 2'b10;
                default:     frsync_q <= 2'b00;
            endcase

            if (state_d == StSettle && state_q != StSettle) begin
                if (adv) begin
                    m_idx_q  <= m_nxt;
                    bw_idx_q <= bw_nxt;
                end
                m_out_q  <= m_cfg;
                bw_out_q <= bw_cfg;
            end else if (bus.manual) begin
                m_out_q  <= bus.m_man;
                bw_out_q <= bus.bw_man;
            end

            if (state_d == StLost && state_q != StLost && n_relock_q != 16'hFFFF) begin
                n_relock_q <= n_relock_q + 16'd1;
            end
        end
    end

    assign bus.m_out       = m_out_q;
    assign bus.bw_out      = bw_out_q;
    assign bus.ss_out      = ss_out_q;
    assign bus.thr_out     = thr_out_q;
    assign bus.frsync_ctrl = frsync_q;
    assign bus.dp_rst      = dp_rst_q;
    assign bus.locked      = locked_q;
    assign bus.state_o     = state_q;
    assign bus.n_relock    = n_relock_q;

endmodule

// File: tb/tb_rx_acq_ctrl.sv
// Directed bench for rx_acq_ctrl with small timing parameters.
module tb_rx_acq_ctrl;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;
    int   n;

    rx_acq_ctrl_if bus ();

    rx_acq_ctrl #(
        .M_MAX    (1),
        .BW_MAX   (1),
        .RST_CYC  (4),
        .DWELL_CYC(50),
        .FRAME_TO (40),
        .LOCK_N   (3),
        .LOSS_N   (2),
        .CNT_W    (24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled/driven 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks while the DUT stays in state s; n = samples observed in s (bounded).
    task automatic wait_state(input logic [2:0] s, output int cnt);
        cnt = 0;
        while (bus.state_o == s && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic pulse_ok();
        bus.crc_ok = 1'b1;
        tick();
        bus.crc_ok = 1'b0;
    endtask

    task automatic pulse_err();
        bus.crc_err = 1'b1;
        tick();
        bus.crc_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        nvec++; if (bus.state_o !== 3'd0) begin nerr++; $display("FAIL reset_state got %0d want 0", bus.state_o); end
        nvec++; if (bus.dp_rst !== 1'b1) begin nerr++; $display("FAIL reset_dp_rst got %b want 1", bus.dp_rst); end
        nvec++; if (bus.locked !== 1'b0) begin nerr++; $display("FAIL reset_locked got %b want 0", bus.locked); end
        nvec++; if ({bus.m_out, bus.bw_out, bus.ss_out} !== 10'd0) begin nerr++; $display("FAIL reset_cfg got %0h want 0", {bus.m_out, bus.bw_out, bus.ss_out}); end
        nvec++; if (bus.thr_out !== 24'd0 || bus.frsync_ctrl !== 2'b00) begin nerr++; $display("FAIL reset_thr_frsync got %0h/%0d want 0/0", bus.thr_out, bus.frsync_ctrl); end
        nvec++; if (bus.n_relock !== 16'd0) begin nerr++; $display("FAIL reset_n_relock got %0d want 0", bus.n_relock); end
    endtask

    task automatic test_scan();
        logic [5:0] exp_idx [4];
        exp_idx[0] = {3'd0, 3'd1};
        exp_idx[1] = {3'd1, 3'd0};
        exp_idx[2] = {3'd1, 3'd1};
        exp_idx[3] = {3'd0, 3'd0};
        rst    = 1'b0;
        bus.en = 1'b1;
        tick();
        nvec++; if (bus.state_o !== 3'd1 || bus.dp_rst !== 1'b1) begin nerr++; $display("FAIL scan_enter_settle got st=%0d dp=%b want 1/1", bus.state_o, bus.dp_rst); end
        for (int i = 0; i < 4; i++) begin
            wait_state(3'd1, n);
            nvec++; if (n !== 4 || bus.state_o !== 3'd2 || bus.dp_rst !== 1'b0) begin nerr++; $display("FAIL scan_settle_len[%0d] got n=%0d st=%0d dp=%b want 4/2/0", i, n, bus.state_o, bus.dp_rst); end
            wait_state(3'd2, n);
            nvec++; if (n !== 50 || bus.state_o !== 3'd1) begin nerr++; $display("FAIL scan_dwell[%0d] got n=%0d st=%0d want 50/1", i, n, bus.state_o); end
            nvec++; if ({bus.m_out, bus.bw_out} !== exp_idx[i] || bus.locked !== 1'b0) begin nerr++; $display("FAIL scan_index[%0d] got %0h lk=%b want %0h/0", i, {bus.m_out, bus.bw_out}, bus.locked, exp_idx[i]); end
        end
        // Step once more so SEARCH sits at (0,1).
        wait_state(3'd1, n);
        wait_state(3'd2, n);
        wait_state(3'd1, n);
        nvec++; if (bus.state_o !== 3'd2 || {bus.m_out, bus.bw_out} !== {3'd0, 3'd1}) begin nerr++; $display("FAIL scan_at_01 got st=%0d idx=%0h want 2/01", bus.state_o, {bus.m_out, bus.bw_out}); end
    endtask

    task automatic test_lock();
        bus.corr_dtct = 1'b1;
        tick();
        bus.corr_dtct = 1'b0;
        nvec++; if (bus.state_o !== 3'd3 || bus.frsync_ctrl !== 2'b01) begin nerr++; $display("FAIL lock_wait_frame got st=%0d fs=%0d want 3/1", bus.state_o, bus.frsync_ctrl); end
        for (int i = 0; i < 3; i++) begin
            pulse_ok();
            if (i < 2) begin
                nvec++; if (bus.state_o !== 3'd3 || bus.locked !== 1'b0) begin nerr++; $display("FAIL lock_ok_partial[%0d] got st=%0d lk=%b want 3/0", i, bus.state_o, bus.locked); end
                repeat (4) tick();
            end
        end
        nvec++; if (bus.state_o !== 3'd4 || bus.locked !== 1'b1 || bus.frsync_ctrl !== 2'b10) begin nerr++; $display("FAIL lock_locked got st=%0d lk=%b fs=%0d want 4/1/2", bus.state_o, bus.locked, bus.frsync_ctrl); end
        nvec++; if ({bus.m_out, bus.bw_out} !== {3'd0, 3'd1}) begin nerr++; $display("FAIL lock_cfg got %0h want 01", {bus.m_out, bus.bw_out}); end
    endtask

    task automatic test_loss();
        pulse_err(); tick();
        pulse_ok();  tick();
        pulse_err(); tick();
        pulse_ok();  tick();
        nvec++; if (bus.state_o !== 3'd4 || bus.locked !== 1'b1) begin nerr++; $display("FAIL loss_mixed got st=%0d lk=%b want 4/1", bus.state_o, bus.locked); end
        bus.crc_err = 1'b1;
        tick();
        nvec++; if (bus.state_o !== 3'd4) begin nerr++; $display("FAIL loss_one_err got st=%0d want 4", bus.state_o); end
        tick();
        bus.crc_err = 1'b0;
        nvec++; if (bus.state_o !== 3'd5 || bus.locked !== 1'b0 || bus.n_relock !== 16'd1) begin nerr++; $display("FAIL loss_lost got st=%0d lk=%b nr=%0d want 5/0/1", bus.state_o, bus.locked, bus.n_relock); end
        tick();
        nvec++; if (bus.state_o !== 3'd1 || bus.dp_rst !== 1'b1 || {bus.m_out, bus.bw_out} !== {3'd0, 3'd1}) begin nerr++; $display("FAIL loss_retry got st=%0d dp=%b idx=%0h want 1/1/01", bus.state_o, bus.dp_rst, {bus.m_out, bus.bw_out}); end
    endtask

    task automatic test_both_pulses();
        wait_state(3'd1, n);
        bus.corr_dtct = 1'b1;
        tick();
        bus.corr_dtct = 1'b0;
        pulse_ok(); tick();
        pulse_ok(); tick();
        bus.crc_ok  = 1'b1;
        bus.crc_err = 1'b1;
        tick();
        bus.crc_ok  = 1'b0;
        bus.crc_err = 1'b0;
        nvec++; if (bus.state_o !== 3'd3) begin nerr++; $display("FAIL both_not_ok got st=%0d want 3", bus.state_o); end
        tick();
        pulse_ok(); tick();
        pulse_ok();
        nvec++; if (bus.state_o !== 3'd3 || bus.locked !== 1'b0) begin nerr++; $display("FAIL both_cleared got st=%0d lk=%b want 3/0", bus.state_o, bus.locked); end
        wait_state(3'd3, n);
        nvec++; if (n !== 40 || bus.state_o !== 3'd1) begin nerr++; $display("FAIL frame_timeout got n=%0d st=%0d want 40/1", n, bus.state_o); end
        nvec++; if ({bus.m_out, bus.bw_out} !== {3'd1, 3'd0}) begin nerr++; $display("FAIL timeout_adv got %0h want 10 (m=1,bw=0)", {bus.m_out, bus.bw_out}); end
    endtask

    task automatic test_manual();
        bus.manual = 1'b1;
        bus.m_man  = 3'd3;
        bus.bw_man = 3'd2;
        wait_state(3'd1, n);
        nvec++; if (bus.state_o !== 3'd2 || {bus.m_out, bus.bw_out} !== {3'd3, 3'd2}) begin nerr++; $display("FAIL manual_cfg got st=%0d idx=%0h want 2/1a", bus.state_o, {bus.m_out, bus.bw_out}); end
        bus.corr_dtct = 1'b1;
        tick();
        bus.corr_dtct = 1'b0;
        pulse_ok(); tick();
        pulse_ok(); tick();
        pulse_ok(); tick();
        nvec++; if (bus.state_o !== 3'd4 || bus.locked !== 1'b1) begin nerr++; $display("FAIL manual_locked got st=%0d lk=%b want 4/1", bus.state_o, bus.locked); end
        bus.bw_man = 3'd4;
        tick();
        nvec++; if (bus.state_o !== 3'd1 || bus.locked !== 1'b0 || bus.bw_out !== 3'd4) begin nerr++; $display("FAIL manual_change got st=%0d lk=%b bw=%0d want 1/0/4", bus.state_o, bus.locked, bus.bw_out); end
        nvec++; if (bus.n_relock !== 16'd1 || bus.dp_rst !== 1'b1) begin nerr++; $display("FAIL manual_relock got nr=%0d dp=%b want 1/1", bus.n_relock, bus.dp_rst); end
    endtask

    task automatic test_en_thr();
        wait_state(3'd1, n);
        bus.corr_dtct = 1'b1;
        tick();
        bus.corr_dtct = 1'b0;
        pulse_ok(); tick();
        pulse_ok(); tick();
        pulse_ok(); tick();
        nvec++; if (bus.state_o !== 3'd4) begin nerr++; $display("FAIL en_relocked got st=%0d want 4", bus.state_o); end
        bus.en = 1'b0;
        tick();
        nvec++; if (bus.state_o !== 3'd0 || bus.dp_rst !== 1'b1 || bus.locked !== 1'b0 || bus.frsync_ctrl !== 2'b00) begin nerr++; $display("FAIL en_drop got st=%0d dp=%b lk=%b fs=%0d want 0/1/0/0", bus.state_o, bus.dp_rst, bus.locked, bus.frsync_ctrl); end
        nvec++; if (bus.thr_out !== 24'h123456) begin nerr++; $display("FAIL thr_man got %0h want 123456", bus.thr_out); end
        bus.thr_sel = 1'b1;
        #1;
        nvec++; if (bus.thr_out !== 24'h123456) begin nerr++; $display("FAIL thr_latency got %0h want 123456", bus.thr_out); end
        tick();
        nvec++; if (bus.thr_out !== 24'hABCDEF) begin nerr++; $display("FAIL thr_auto got %0h want abcdef", bus.thr_out); end
        bus.thr_sel = 1'b0;
        tick();
        nvec++; if (bus.thr_out !== 24'h123456) begin nerr++; $display("FAIL thr_back got %0h want 123456", bus.thr_out); end
        nvec++; if (bus.ss_out !== 4'h9) begin nerr++; $display("FAIL ss_pass got %0h want 9", bus.ss_out); end
    endtask

    initial begin
        nvec          = 0;
        nerr          = 0;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.manual    = 1'b0;
        bus.m_man     = 3'd0;
        bus.bw_man    = 3'd0;
        bus.ss_man    = 4'h0;
        bus.thr_sel   = 1'b0;
        bus.thr_man   = 24'h123456;
        bus.thr_auto  = 24'hABCDEF;
        bus.corr_dtct = 1'b0;
        bus.crc_ok    = 1'b0;
        bus.crc_err   = 1'b0;
        test_reset();
        test_scan();
        test_lock();
        test_loss();
        test_both_pulses();
        bus.ss_man = 4'h9;
        bus.manual = 1'b0;
        tick();
        test_manual();
        test_en_thr();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
